// File: rtl/rng_arb_pkg.sv
// Shared types and constants for the RNG request arbiter.
package rng_arb_pkg;

    localparam int RNG_W = 64;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RESEED = 2'd1,
        SETTLE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rng_arb_fifo.sv
// DEPTH x RNG_W word FIFO with push/pop/flush; head word is readable combinationally.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module rng_arb_fifo
    import rng_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  logic [RNG_W-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [RNG_W-1:0]       head_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [RNG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             full;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_reg + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Storage carries no reset; occupancy is tracked solely by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign level     = level_reg;

endmodule

// File: rtl/rng_req_arbiter.sv
// Hands out buffered RNG words round-robin, once each, and sequences periodic reseeding.
// Optional repetition health test enabled by defining RNG_ARB_HEALTH_EN.
module rng_req_arbiter
    import rng_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 4,
    parameter int RESEED_CNT = 256,
    parameter int SETTLE_CYC = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rng_valid_i,
    input  logic [RNG_W-1:0]       rng_data_i,
    output logic                   reseed_o,
    input  logic                   force_reseed_i,
    input  logic [NUM_REQ-1:0]     req_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [RNG_W-1:0]       data_o,
    output logic [$clog2(DEPTH):0] level_o,
`ifdef RNG_ARB_HEALTH_EN
    output logic                   health_err_o,
`endif
    output logic                   busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RESEED_CNT + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    arb_state_e             state_reg;
    logic [PTR_W-1:0]       rr_ptr_reg;
    logic [PTR_W-1:0]       rr_ptr_next;
    logic [CNT_W-1:0]       consumed_reg;
    logic [CNT_W-1:0]       consumed_next;
    logic [SET_W-1:0]       settle_reg;
    logic                   reseed_reg;
    logic                   busy_reg;

    logic [RNG_W-1:0]       fifo_head;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   fifo_empty;
    logic                   in_fill;
    logic                   push_en;
    logic                   grant_en;
    logic                   reseed_due;
    logic                   health_dup;
    logic                   health_trip;

    logic [NUM_REQ-1:0]     req_hi;
    logic [PTR_W-1:0]       gnt_idx;
    logic                   gnt_any;

    assign in_fill    = (state_reg == FILL);
    assign fifo_empty = (fifo_level == '0);

    // Requests at or above the pointer take priority; otherwise wrap to the lowest.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_hi
            assign req_hi[gi] = req_i[gi] && (PTR_W'(gi) >= rr_ptr_reg);
        end
    endgenerate

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_idx = PTR_W'(i);
                gnt_any = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    assign grant_en    = in_fill && !fifo_empty && gnt_any;
    assign rr_ptr_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt_o[gi] = grant_en && (gnt_idx == PTR_W'(gi));
        end
    endgenerate

    assign data_o = grant_en ? fifo_head : '0;

    always_comb begin
        consumed_next = consumed_reg;
        if (grant_en && (consumed_reg != CNT_W'(RESEED_CNT))) begin
            consumed_next = consumed_reg + CNT_W'(1);
        end
    end

    // Decision uses the post-grant count so the final grant still goes out.
    assign reseed_due = (consumed_next == CNT_W'(RESEED_CNT)) || force_reseed_i || health_trip;
    assign push_en    = in_fill && rng_valid_i && !health_dup;

`ifdef RNG_ARB_HEALTH_EN
    logic [RNG_W-1:0] last_word_reg;
    logic             last_vld_reg;
    logic [3:0]       rep_cnt_reg;
    logic             health_err_reg;
    logic             word_taken;

    assign health_dup  = in_fill && rng_valid_i && last_vld_reg && (rng_data_i == last_word_reg);
    assign health_trip = health_dup && (rep_cnt_reg >= 4'd2);
    assign word_taken  = push_en && ((fifo_level != ($clog2(DEPTH)+1)'(DEPTH)) || grant_en);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_word_reg  <= '0;
            last_vld_reg   <= 1'b0;
            rep_cnt_reg    <= '0;
            health_err_reg <= 1'b0;
        end else begin
            if (word_taken) begin
                last_word_reg <= rng_data_i;
                last_vld_reg  <= 1'b1;
                rep_cnt_reg   <= '0;
            end else if (health_dup && (rep_cnt_reg != 4'hF)) begin
                rep_cnt_reg <= rep_cnt_reg + 4'd1;
            end
            if (health_trip) begin
                health_err_reg <= 1'b1;
            end
        end
    end

    assign health_err_o = health_err_reg;
`else
    assign health_dup  = 1'b0;
    assign health_trip = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= FILL;
            rr_ptr_reg   <= '0;
            consumed_reg <= '0;
            settle_reg   <= '0;
            reseed_reg   <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (grant_en) begin
                        rr_ptr_reg <= rr_ptr_next;
                    end
                    consumed_reg <= consumed_next;
                    if (reseed_due) begin
                        state_reg  <= RESEED;
                        reseed_reg <= 1'b1;
                        busy_reg   <= 1'b1;
                    end
                end
                RESEED: begin
                    state_reg    <= SETTLE;
                    reseed_reg   <= 1'b0;
                    consumed_reg <= '0;
                    settle_reg   <= '0;
                end
                SETTLE: begin
                    if (settle_reg == SET_W'(SETTLE_CYC - 1)) begin
                        state_reg  <= FILL;
                        busy_reg   <= 1'b0;
                        settle_reg <= '0;
                    end else begin
                        settle_reg <= settle_reg + SET_W'(1);
                    end
                end
                default: begin
                    state_reg  <= FILL;
                    reseed_reg <= 1'b0;
                    busy_reg   <= 1'b0;
                end
            endcase
        end
    end

    rng_arb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (push_en),
        .push_data(rng_data_i),
        .pop      (grant_en),
        .flush    (state_reg == RESEED),
        .head_data(fifo_head),
        .level    (fifo_level)
    );

    assign reseed_o = reseed_reg;
    assign busy_o   = busy_reg;
    assign level_o  = fifo_level;

endmodule

// File: tb/tb_rng_req_arbiter.sv
// Directed vector-table bench for rng_req_arbiter (health test checked when RNG_ARB_HEALTH_EN is defined).
module tb_rng_req_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DEPTH      = 4;
    localparam int RESEED_CNT = 4;
    localparam int SETTLE_CYC = 4;

    logic        clk;
    logic        rst_n;
    logic        rng_valid;
    logic [63:0] rng_data;
    logic        reseed;
    logic        force_reseed;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [63:0] data;
    logic [2:0]  level;
    logic        busy;
`ifdef RNG_ARB_HEALTH_EN
    logic        health_err;
`endif

    int checks = 0;
    int errors = 0;

    rng_req_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DEPTH     (DEPTH),
        .RESEED_CNT(RESEED_CNT),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rng_valid_i   (rng_valid),
        .rng_data_i    (rng_data),
        .reseed_o      (reseed),
        .force_reseed_i(force_reseed),
        .req_i         (req),
        .gnt_o         (gnt),
        .data_o        (data),
        .level_o       (level),
`ifdef RNG_ARB_HEALTH_EN
        .health_err_o  (health_err),
`endif
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [63:0] dat;
        logic        frc;
        logic [3:0]  req;
        logic [3:0]  e_gnt;
        logic [63:0] e_dat;
        logic [2:0]  e_lvl;
        logic        e_rs;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic vld, logic [63:0] dat, logic frc, logic [3:0] rq,
                                logic [3:0] eg, logic [63:0] ed, logic [2:0] el, logic ers, logic eb);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dat = dat; v.frc = frc; v.req = rq;
        v.e_gnt = eg; v.e_dat = ed; v.e_lvl = el; v.e_rs = ers; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rng_valid    = 1'b0;
        rng_data     = '0;
        force_reseed = 1'b0;
        req          = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        int rs_cnt;
        bit done;

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_data", data, 0);
        chk("rst_level", level, 0);
        chk("rst_reseed", reseed, 0);
        chk("rst_busy", busy, 0);
`ifdef RNG_ARB_HEALTH_EN
        chk("rst_health", health_err, 0);
`endif

        // Fill and single consumer
        vecs.push_back(mk(1, 1, 64'hA1, 0, 4'b0000, 4'b0000, 64'h0,  0, 0, 0));
        vecs.push_back(mk(0, 1, 64'hA2, 0, 4'b0000, 4'b0000, 64'h0,  1, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0001, 4'b0001, 64'hA1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0001, 4'b0001, 64'hA2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0001, 4'b0000, 64'h0,  0, 0, 0));
        // Overflow, round-robin, auto reseed after 4 grants, settle discards, no bypass
        vecs.push_back(mk(1, 1, 64'hB000_0000_0000_00B1, 0, 4'b0000, 4'b0000, 64'h0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 64'hB000_0000_0000_00B2, 0, 4'b0000, 4'b0000, 64'h0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 64'hB000_0000_0000_00B3, 0, 4'b0000, 4'b0000, 64'h0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 64'hB000_0000_0000_00B4, 0, 4'b0000, 4'b0000, 64'h0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 64'hB000_0000_0000_00B5, 0, 4'b0000, 4'b0000, 64'h0, 4, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0, 0, 4'b1111, 4'b0001, 64'hB000_0000_0000_00B1, 4, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0, 0, 4'b1111, 4'b0010, 64'hB000_0000_0000_00B2, 3, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0, 0, 4'b1111, 4'b0100, 64'hB000_0000_0000_00B3, 2, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0, 0, 4'b1111, 4'b1000, 64'hB000_0000_0000_00B4, 1, 0, 0));
        vecs.push_back(mk(0, 1, 64'hC1, 0, 4'b1111, 4'b0000, 64'h0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 64'hC2, 0, 4'b1111, 4'b0000, 64'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'hC3, 0, 4'b1111, 4'b0000, 64'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'hC4, 0, 4'b1111, 4'b0000, 64'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'hC5, 0, 4'b1111, 4'b0000, 64'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'hD1, 0, 4'b1111, 4'b0000, 64'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b1111, 4'b0001, 64'hD1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0000, 4'b0000, 64'h0, 0, 0, 0));
        // Forced reseed with 3 buffered words; force during SETTLE ignored
        vecs.push_back(mk(1, 1, 64'hE1, 0, 4'b0000, 4'b0000, 64'h0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 64'hE2, 0, 4'b0000, 4'b0000, 64'h0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 64'hE3, 0, 4'b0000, 4'b0000, 64'h0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  1, 4'b0000, 4'b0000, 64'h0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0000, 4'b0000, 64'h0, 3, 1, 1));
        vecs.push_back(mk(0, 1, 64'hF0, 1, 4'b0000, 4'b0000, 64'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'hF0, 1, 4'b0010, 4'b0000, 64'h0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 64'h0,  1, 4'b0000, 4'b0000, 64'h0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0000, 4'b0000, 64'h0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 64'hF1, 0, 4'b0100, 4'b0000, 64'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0100, 4'b0100, 64'hF1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0000, 4'b0000, 64'h0, 0, 0, 0));
        // Push and pop together at full, pointer wrap, reseed flushes leftover word
        vecs.push_back(mk(1, 1, 64'h61, 0, 4'b0000, 4'b0000, 64'h0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 64'h62, 0, 4'b0000, 4'b0000, 64'h0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 64'h63, 0, 4'b0000, 4'b0000, 64'h0, 2, 0, 0));
        vecs.push_back(mk(0, 1, 64'h64, 0, 4'b0000, 4'b0000, 64'h0, 3, 0, 0));
        vecs.push_back(mk(0, 1, 64'h65, 0, 4'b0010, 4'b0010, 64'h61, 4, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0010, 4'b0010, 64'h62, 4, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0000, 4'b0000, 64'h0,  3, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b1000, 4'b1000, 64'h63, 3, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0101, 4'b0001, 64'h64, 2, 0, 0));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0100, 4'b0000, 64'h0,  1, 1, 1));
        vecs.push_back(mk(0, 0, 64'h0,  0, 4'b0000, 4'b0000, 64'h0,  0, 0, 1));

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].rst) do_reset();
            rng_valid    = vecs[i].vld;
            rng_data     = vecs[i].dat;
            force_reseed = vecs[i].frc;
            req          = vecs[i].req;
            #1;
            $display("vec %0d req=%b gnt=%b data=%h level=%0d reseed=%b busy=%b",
                     i, req, gnt, data, level, reseed, busy);
            chk($sformatf("v%0d_gnt", i), gnt, vecs[i].e_gnt);
            chk($sformatf("v%0d_data", i), data, vecs[i].e_dat);
            chk($sformatf("v%0d_level", i), level, vecs[i].e_lvl);
            chk($sformatf("v%0d_reseed", i), reseed, vecs[i].e_rs);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
        end

        // Reset in the middle of a reseed pulse abandons it at once
        @(negedge clk);
        do_reset();
        rng_valid = 1'b1; rng_data = 64'h71;
        @(negedge clk);
        idle_inputs(); force_reseed = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mid_reseed_pulse", reseed, 1);
        rst_n = 1'b0;
        #1;
        $display("mid-reseed reset: reseed=%b busy=%b level=%0d", reseed, busy, level);
        chk("mid_rst_reseed", reseed, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_level", level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rng_valid = 1'b1; rng_data = 64'h72;
        #1;
        chk("post_rst_busy", busy, 0);
        @(negedge clk);
        idle_inputs(); req = 4'b0001;
        #1;
        $display("post-reset grant: gnt=%b data=%h", gnt, data);
        chk("post_rst_gnt", gnt, 4'b0001);
        chk("post_rst_data", data, 64'h72);

        // Busy window length after a forced reseed, bounded
        @(negedge clk);
        do_reset();
        force_reseed = 1'b1;
        @(negedge clk);
        idle_inputs();
        busy_cnt = 0; rs_cnt = 0; done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            busy_cnt++;
            if (reseed) rs_cnt++;
            @(negedge clk);
        end
        $display("busy window: %0d cycles, reseed pulses %0d", busy_cnt, rs_cnt);
        chk("busy_window_done", done, 1);
        chk("busy_window_len", busy_cnt, 1 + SETTLE_CYC);
        chk("reseed_pulse_len", rs_cnt, 1);

`ifdef RNG_ARB_HEALTH_EN
        // Repeated word: stored once, third repeat latches the error and forces a reseed
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rng_valid = 1'b1; rng_data = 64'h55;
            #1;
            chk($sformatf("hl_err_pre%0d", k), health_err, 0);
            @(negedge clk);
        end
        idle_inputs();
        #1;
        $display("health: err=%b reseed=%b level=%0d", health_err, reseed, level);
        chk("hl_err_set", health_err, 1);
        chk("hl_reseed", reseed, 1);
        chk("hl_level", level, 1);
        repeat (SETTLE_CYC + 2) @(negedge clk);
        #1;
        chk("hl_err_sticky", health_err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
